vram_line_reader: RTL

Video-side consumer of the dual-clock VRAM's read-only port. On a `start` pulse it fetches `length` consecutive words from a base address and streams them out as a pixel/tile-data stream with valid/ready backpressure. Read requests are credit-throttled against a small output FIFO, so no word is ever dropped when the downstream stalls. It runs entirely in the video clock domain and sits between the VRAM read port and the line/tile renderer.

---
 rtl/vram_line_reader.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/vram_line_reader.sv
// -----------------------------------------------------------------------------
// vram_line_reader
//
// Video-clock-domain burst reader for the VRAM read-only port. A start pulse
// in IDLE latches a base address and a word count. The block then issues
// consecutive single-word reads and streams the returned words out through a
// small FIFO with a valid/ready handshake. Reads are credit-throttled against
// the FIFO, so no word is lost when the downstream stalls.
//
// Ports
//   clk, rst_n  : video clock, asynchronous active-low reset
//   start       : burst request, sampled only in IDLE
//   base_addr   : first word address, latched on an accepted start
//   length      : word count, latched on an accepted start (0 = no-op burst)
//   busy        : burst in progress (FETCH or DRAIN)
//   done        : one-cycle pulse at burst completion
//   mem_addr    : registered VRAM read address
//   mem_re      : registered read strobe
//   mem_dout    : RAM read data, valid the cycle after mem_re
//   px_valid    : FIFO non-empty
//   px_data     : FIFO head word (0 while empty)
//   px_last     : head word is the final word of the burst
//   px_ready    : downstream accept
// -----------------------------------------------------------------------------
module vram_line_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  px_valid,
  output logic [DATA_WIDTH-1:0] px_data,
  output logic                  px_last,
  input  logic                  px_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Control state
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;       // next address to issue
  logic [LEN_WIDTH-1:0]  r_left;       // reads still to issue
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_re;
  logic                  r_mem_last;   // read on the bus is the burst's final one
  logic                  r_rd_pend;    // data for last cycle's read arrives now
  logic                  r_pend_last;
  logic                  r_done;

  // Output FIFO
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic                  r_fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  // Combinational
  state_t                w_state_next;
  logic                  w_issue;
  logic                  w_issue_last;
  logic                  w_load;
  logic                  w_done_next;
  logic                  w_valid;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head_last;
  logic                  w_credit;
  logic [CNT_W:0]        w_inflight;
  logic [ADDR_WIDTH-1:0] w_issue_addr;
  logic [LEN_WIDTH-1:0]  w_left_now;

  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid & px_ready;
  assign w_push      = r_rd_pend;
  assign w_head_last = r_fifo_last[r_rd_ptr];

  // Every word that will eventually occupy a FIFO slot: already buffered,
  // returning from the RAM this cycle, and the read currently on the bus.
  // Pops in this cycle are deliberately not credited, which keeps the
  // decision a function of registered state only.
  assign w_inflight = {1'b0, r_count}
                    + (CNT_W+1)'(r_mem_re)
                    + (CNT_W+1)'(r_rd_pend);
  assign w_credit   = (w_inflight < (CNT_W+1)'(FIFO_DEPTH));

  // The first read issues in the same edge that accepts start, so the
  // request parameters bypass the latch registers for that one cycle.
  assign w_issue_addr = w_load ? base_addr : r_addr;
  assign w_left_now   = w_load ? length    : r_left;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    w_load       = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            w_done_next = 1'b1;
          end else begin
            w_load       = 1'b1;
            w_issue      = 1'b1;
            w_issue_last = (length == LEN_WIDTH'(1));
            w_state_next = (length == LEN_WIDTH'(1)) ? S_DRAIN : S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (w_credit) begin
          w_issue      = 1'b1;
          w_issue_last = (r_left == LEN_WIDTH'(1));
          if (r_left == LEN_WIDTH'(1)) w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && w_head_last) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_left      <= '0;
      r_mem_addr  <= '0;
      r_mem_re    <= 1'b0;
      r_mem_last  <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_pend_last <= 1'b0;
      r_done      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_done      <= w_done_next;
      r_mem_re    <= w_issue;
      r_mem_last  <= w_issue_last;
      r_rd_pend   <= r_mem_re;
      r_pend_last <= r_mem_re & r_mem_last;
      if (w_issue) begin
        r_mem_addr <= w_issue_addr;
        r_addr     <= w_issue_addr + ADDR_WIDTH'(1);
        r_left     <= w_left_now - LEN_WIDTH'(1);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; only the pointers and count do. Entries
  // are never observed before being written because px_data is forced to 0
  // while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= mem_dout;
      r_fifo_last[r_wr_ptr] <= r_pend_last;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign mem_addr = r_mem_addr;
  assign mem_re   = r_mem_re;
  assign px_valid = w_valid;
  assign px_data  = w_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign px_last  = w_valid & w_head_last;

endmodule
